nbr_window: RTL and testbench
=============================

Name: nbr_window

Overview:
- Streaming neighbourhood generator for raster-order pixel streams, feeding the connected-component labelling stage.
- For every accepted pixel P at (x,y) it presents the causal 8-connected neighbours: A = (x-1,y-1), B = (x,y-1), C = (x+1,y-1) and D = (x-1,y).
- The previous row is held in one simple dual-port RAM (`ram`, 1-cycle registered read) used as a line buffer. Column and row counters track position; no frame storage.

Parameters:
- DATA_WIDTH, 8: pixel width.
- IMG_WIDTH, 640: pixels per row; must be at least 3.
- COL_WIDTH, 10: column counter and line-buffer address width; 2^COL_WIDTH >= IMG_WIDTH.
- IMG_HEIGHT, 480: rows per frame.
- ROW_WIDTH, 9: row counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  in_data accepted this cycle; no backpressure.
- in_data  in  DATA_WIDTH  pixel P.
- in_sof  in  1  start of frame; present only with NBR_SOF_EN.
- out_valid  out  1  outputs valid, exactly one cycle after each accept.
- out_p  out  DATA_WIDTH  pixel P.
- out_a  out  DATA_WIDTH  neighbour A.
- out_b  out  DATA_WIDTH  neighbour B.
- out_c  out  DATA_WIDTH  neighbour C.
- out_d  out  DATA_WIDTH  neighbour D.
- out_x  out  COL_WIDTH  column of P.
- out_y  out  ROW_WIDTH  row of P.
- frame_done  out  1  pulses with out_valid for pixel (IMG_WIDTH-1, IMG_HEIGHT-1).

Behaviour:
- Reset (async assert, sync deassert use):
  - all outputs 0; col and row counters 0; history registers 0.
  - RAM contents are not cleared; stale contents are hidden by row-0 masking.
- Accept: cycle with in_valid=1.
  - col increments; at IMG_WIDTH-1 col wraps to 0 and row increments.
  - at (IMG_WIDTH-1, IMG_HEIGHT-1) both counters wrap to 0.
- Line buffer, on each accept:
  - write in_data at address col.
  - read address (col+1) mod IMG_WIDTH. At col=IMG_WIDTH-1 this reads address 0, which still holds the current row's pixel 0, i.e. B for the next row's first pixel.
- Output stage: registered, latency exactly 1 cycle after accept.
  - raw_c = RAM read data.
  - raw_b = raw_c of the previous accept.
  - raw_a = raw_b of the previous accept.
  - raw_d = previous accepted in_data.
  - Raw history registers update on accept only and are never masked.
- Output masking, applied to the out_* registers only:
  - y=0: out_a = out_b = out_c = 0.
  - x=0: out_a = out_d = 0.
  - x=IMG_WIDTH-1: out_c = 0.
- Stalls (in_valid=0):
  - out_valid=0; out_* data registers hold their last values; counters and history hold.
  - RAM read address is held, so read data stays stable; any number of idle cycles gives results identical to back-to-back input.
- Back-to-back frames need no gap; row 0 of frame N+1 is masked, so it is unaffected by frame N data.
- Reset mid-frame aborts the frame. The next accepted pixel is (0,0).

Optional Feature:
- Macro NBR_SOF_EN.
- Defined: in_sof port exists. An accept with in_sof=1 forces that pixel to (0,0) regardless of counter state; history is used as normal but masked by row 0 / col 0.
  - in_sof without in_valid is ignored.
  - The realigned frame continues normally; frame_done fires only on a true (IMG_WIDTH-1, IMG_HEIGHT-1) pixel.
- Undefined: no in_sof port; alignment comes from reset and counter wrap only.

Test Plan:
- Common setup: IMG_WIDTH=4, IMG_HEIGHT=3; pixel (x,y) = 16*y + x + 1.
- Full frame, continuous valid:
  - (1,1)=0x12 -> A=0x01, B=0x02, C=0x03, D=0x11.
  - (0,1)=0x11 -> A=0, B=0x01, C=0x02, D=0.
  - (3,1)=0x14 -> A=0x03, B=0x04, C=0, D=0x13.
- Row 0 masking: all row-0 outputs have A=B=C=0. (2,0) gives D=0x02. frame_done is high only with (3,2)=0x24.
- Stalls: same frame with 3 idle cycles after every pixel -> identical output values. out_valid is high exactly 1 cycle after each accept, 12 pulses total.
- Back-to-back frames:
  - second frame with values +0x80 -> row 0 A/B/C=0, despite the RAM holding 0x21-0x24.
  - (1,1)=0x92 -> A=0x81, B=0x82, C=0x83, D=0x91.
- Reset mid-frame:
  - reset_n low for 1 cycle after 6 accepts -> all outputs 0.
  - new frame (+0x80) matches the back-to-back results exactly.
- NBR_SOF_EN:
  - in_sof with the 3rd pixel of a frame -> out_x=0, out_y=0, A=B=C=D=0.
  - after 11 further pixels, frame_done pulses on the realigned (3,2).

Source files
------------

// File: rtl/nbr_window.sv
// Causal 8-neighbour window (A,B,C,D around P) for raster streams, one-row line buffer.
// Latency 1 cycle, no backpressure. Optional in_sof realignment with `define NBR_SOF_EN.
module nbr_window #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_WIDTH  = 10,
  parameter int IMG_HEIGHT = 480,
  parameter int ROW_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef NBR_SOF_EN
  input  logic                  in_sof,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_p,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic [DATA_WIDTH-1:0] out_d,
  output logic [COL_WIDTH-1:0]  out_x,
  output logic [ROW_WIDTH-1:0]  out_y,
  output logic                  frame_done
);

  localparam logic [COL_WIDTH-1:0] LAST_COL    = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] LAST_COL_M1 = COL_WIDTH'(IMG_WIDTH - 2);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW    = ROW_WIDTH'(IMG_HEIGHT - 1);

  logic                  sof;
  logic [COL_WIDTH-1:0]  col, cur_col, rd_addr;
  logic [ROW_WIDTH-1:0]  row, cur_row;
  logic [DATA_WIDTH-1:0] mem [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] raw_a, raw_b, raw_c, raw_d;
  logic                  first_col, last_col, first_row;

`ifdef NBR_SOF_EN
  assign sof = in_valid & in_sof;
`else
  assign sof = 1'b0;
`endif

  assign cur_col   = sof ? '0 : col;
  assign cur_row   = sof ? '0 : row;
  assign first_col = (cur_col == '0);
  assign last_col  = (cur_col == LAST_COL);
  assign first_row = (cur_row == '0);

  // The RAM is read every cycle. On an accept the address already points one
  // pixel ahead, so the C neighbour of the next pixel is ready on its accept edge;
  // while idle it points at col+1 so the pending pixel's C stays on rd_q.
  always_comb begin
    rd_addr = '0;
    if (in_valid) begin
      if (last_col)
        rd_addr = COL_WIDTH'(1);
      else if (cur_col == LAST_COL_M1)
        rd_addr = '0;
      else
        rd_addr = cur_col + COL_WIDTH'(2);
    end else begin
      rd_addr = (col == LAST_COL) ? '0 : col + COL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid)
      mem[cur_col] <= in_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col <= '0;
        row <= (cur_row == LAST_ROW) ? '0 : cur_row + ROW_WIDTH'(1);
      end else begin
        col <= cur_col + COL_WIDTH'(1);
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_a <= '0;
      raw_b <= '0;
      raw_c <= '0;
      raw_d <= '0;
    end else if (in_valid) begin
      raw_c <= rd_q;
      raw_b <= raw_c;
      raw_a <= raw_b;
      raw_d <= in_data;
    end
  end

  // Masking applies to the presented window only; the raw history stays intact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_p      <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_c      <= '0;
      out_d      <= '0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      frame_done <= in_valid && last_col && (cur_row == LAST_ROW);
      if (in_valid) begin
        out_p <= in_data;
        out_a <= (first_row || first_col) ? '0 : raw_b;
        out_b <= first_row ? '0 : raw_c;
        out_c <= (first_row || last_col) ? '0 : rd_q;
        out_d <= first_col ? '0 : raw_d;
        out_x <= cur_col;
        out_y <= cur_row;
      end
    end
  end

endmodule

// File: tb/tb_nbr_window.sv
// Scoreboard bench for nbr_window on a 4x3 image; pixel (x,y) = base + 16*y + x + 1.
module tb_nbr_window;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [1:0] x;
    logic [1:0] y;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic       out_valid;
  logic [7:0] out_p, out_a, out_b, out_c, out_d;
  logic [1:0] out_x, out_y;
  logic       frame_done;

  nbr_window #(
    .DATA_WIDTH(8), .IMG_WIDTH(4), .COL_WIDTH(2), .IMG_HEIGHT(3), .ROW_WIDTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
`ifdef NBR_SOF_EN
    .in_sof(in_sof),
`endif
    .out_valid(out_valid), .out_p(out_p), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_d(out_d), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  int   pulse_base = 0;
  int   zero_req = 0, zero_seen = 0;
  int   pulse_req = 0, pulse_seen = 0;
  int   end_req = 0, end_seen = 0;
  logic prev_acc;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) prev_acc <= 1'b0;
    else          prev_acc <= in_valid;

  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (reset_n) begin
      tests++;
      if (out_valid !== prev_acc) begin
        fails++;
        $display("FAIL valid_latency: out_valid=%b required %b", out_valid, prev_acc);
      end
      if (out_valid === 1'b1) begin
        pulses++;
        act = {out_p, out_a, out_b, out_c, out_d, out_x, out_y, frame_done};
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL pixel(%0d,%0d): got p=%h a=%h b=%h c=%h d=%h x=%0d y=%0d fd=%b required p=%h a=%h b=%h c=%h d=%h x=%0d y=%0d fd=%b",
                     e.x, e.y, out_p, out_a, out_b, out_c, out_d, out_x, out_y, frame_done,
                     e.p, e.a, e.b, e.c, e.d, e.x, e.y, e.fd);
          end
        end
      end
    end
    if (zero_req != zero_seen) begin
      zero_seen = zero_req;
      tests++;
      if ({out_valid, out_p, out_a, out_b, out_c, out_d, out_x, out_y, frame_done} !== '0) begin
        fails++;
        $display("FAIL reset_zero: got v=%b p=%h a=%h b=%h c=%h d=%h x=%0d y=%0d fd=%b required all 0",
                 out_valid, out_p, out_a, out_b, out_c, out_d, out_x, out_y, frame_done);
      end
    end
    if (pulse_req != pulse_seen) begin
      pulse_seen = pulse_req;
      tests++;
      if (pulses - pulse_base != 12) begin
        fails++;
        $display("FAIL stall_pulses: got %0d required 12", pulses - pulse_base);
      end
    end
    if (end_req != end_seen) begin
      end_seen = end_req;
      tests++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL drain: %0d outputs missing, required 0", q.size());
      end
    end
  end

  function automatic logic [7:0] pix(input int x, input int y, input logic [7:0] base);
    return base + 8'(16 * y + x + 1);
  endfunction

  function automatic exp_t mk(input int x, input int y, input logic [7:0] base);
    exp_t e;
    e.p  = pix(x, y, base);
    e.a  = (y == 0 || x == 0) ? 8'h00 : pix(x - 1, y - 1, base);
    e.b  = (y == 0)           ? 8'h00 : pix(x, y - 1, base);
    e.c  = (y == 0 || x == 3) ? 8'h00 : pix(x + 1, y - 1, base);
    e.d  = (x == 0)           ? 8'h00 : pix(x - 1, y, base);
    e.x  = 2'(x);
    e.y  = 2'(y);
    e.fd = (x == 3 && y == 2);
    return e;
  endfunction

  task automatic send(input exp_t e, input logic s, input int idle);
    q.push_back(e);
    in_valid = 1'b1;
    in_data  = e.p;
    in_sof   = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [7:0] base, input int idle, input int npix);
    for (int i = 0; i < npix; i++)
      send(mk(i % 4, i / 4, base), 1'b0, idle);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    zero_req++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sof   = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // continuous frame, then a back-to-back frame over stale line-buffer data
    frame(8'h00, 0, 12);
    frame(8'h80, 0, 12);
    @(posedge clk); #1;

    // same frame with three idle cycles after every pixel
    pulse_base = pulses;
    frame(8'h00, 3, 12);
    @(posedge clk); #1;
    pulse_req++;
    @(posedge clk); #1;

    // abort after six pixels; the next frame restarts at (0,0)
    frame(8'h00, 0, 6);
    @(posedge clk); #1;
    do_reset();
    frame(8'h80, 0, 12);
    @(posedge clk); #1;

`ifdef NBR_SOF_EN
    do_reset();
    e = mk(0, 0, 8'h00); e.p = 8'h55;
    send(e, 1'b0, 0);
    e = mk(1, 0, 8'h00); e.p = 8'h66; e.d = 8'h55;
    send(e, 1'b0, 0);
    send(mk(0, 0, 8'h00), 1'b1, 0);
    for (int i = 1; i < 12; i++)
      send(mk(i % 4, i / 4, 8'h00), 1'b0, 0);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    end_req++;
    @(negedge clk);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
